// File: rtl/floo_axis_link_scheduler.sv
// Purpose : credit-based scheduler sharing one AXIS serial-link egress between NumChan NoC channels.
// Latency : zero-cycle grant in IDLE (combinational round-robin); bursts of up to MaxBurst beats per channel.
// Backpr. : out_valid_o/sel_idx_o are frozen while out_ready_i is low; credits gate eligibility.
// Ports   : clk_i/rst_i (async active-high); chan_valid_i/chan_ready_o per-channel handshake;
//           out_valid_o/out_ready_i egress handshake; sel_idx_o steers the external payload mux;
//           credit_ret_i frees one remote slot per pulse; credit_cnt_o/credit_err_o credit status.
module floo_axis_link_scheduler #(
  parameter int unsigned NumChan     = 3,
  parameter int unsigned InitCredits = 4,
  parameter int unsigned MaxBurst    = 2,
  localparam int unsigned IdxWidth   = $clog2(NumChan),
  localparam int unsigned CntWidth   = $clog2(InitCredits + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumChan-1:0]           chan_valid_i,
  output logic [NumChan-1:0]           chan_ready_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [IdxWidth-1:0]          sel_idx_o,
  input  logic [NumChan-1:0]           credit_ret_i,
  output logic [NumChan*CntWidth-1:0]  credit_cnt_o,
  output logic                         credit_err_o
);

  localparam int unsigned BeatWidth = $clog2(MaxBurst + 1);

  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_e;
  typedef logic [IdxWidth-1:0]  idx_t;
  typedef logic [CntWidth-1:0]  cnt_t;
  typedef logic [BeatWidth-1:0] beat_t;

  state_e state_q, state_d;
  idx_t   lock_q, lock_d;
  idx_t   rr_q, rr_d;
  beat_t  beat_q, beat_d;
  logic   err_q, err_set;
  cnt_t   credit_q [NumChan];
  cnt_t   credit_d [NumChan];

  logic [NumChan-1:0] elig;
  logic               rr_any;
  idx_t               rr_win, cand, sel;
  logic               valid_raw, hs;
  beat_t              beat_inc;

  // Pointer increment that wraps at NumChan, so non-power-of-two channel counts never
  // produce an out-of-range index.
  function automatic idx_t wrap_inc(input idx_t i);
    if (i == idx_t'(NumChan - 1)) return '0;
    else return i + idx_t'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(NumChan); i++) begin
      elig[i] = chan_valid_i[i] && (credit_q[i] != '0);
    end
  end

  // Round-robin search starting at the pointer; first eligible candidate wins.
  always_comb begin
    rr_any = 1'b0;
    rr_win = rr_q;
    cand   = rr_q;
    for (int k = 0; k < int'(NumChan); k++) begin
      if (!rr_any && elig[cand]) begin
        rr_any = 1'b1;
        rr_win = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    valid_raw = 1'b0;
    sel       = rr_win;
    case (state_q)
      IDLE: begin
        valid_raw = rr_any;
        sel       = rr_win;
      end
      HOLD: begin
        // Offer already made on the link: keep it until it is taken.
        valid_raw = 1'b1;
        sel       = lock_q;
      end
      BURST: begin
        valid_raw = elig[lock_q];
        sel       = lock_q;
      end
      default: ;
    endcase
  end

  // Outputs are forced quiet while reset is held so a mid-burst reset drops the beat at once.
  assign out_valid_o = valid_raw & ~rst_i;
  assign sel_idx_o   = rst_i ? '0 : sel;
  assign hs          = out_valid_o & out_ready_i;
  assign beat_inc    = beat_q + beat_t'(1);

  for (genvar g = 0; g < int'(NumChan); g++) begin : g_chan
    assign chan_ready_o[g] = hs && (sel == idx_t'(g));
    assign credit_cnt_o[g*CntWidth +: CntWidth] = credit_q[g];
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE, HOLD: begin
        // In HOLD sel equals the lock, so the same handshake rules apply.
        if (hs) begin
          if (MaxBurst > 1) begin
            state_d = BURST;
            lock_d  = sel;
            beat_d  = beat_t'(1);
          end else begin
            state_d = IDLE;
            rr_d    = wrap_inc(sel);
          end
        end else if (out_valid_o) begin
          state_d = HOLD;
          lock_d  = sel;
        end
      end
      BURST: begin
        if (hs) begin
          if (beat_inc == beat_t'(MaxBurst)) begin
            state_d = IDLE;
            rr_d    = wrap_inc(lock_q);
            beat_d  = '0;
          end else begin
            beat_d  = beat_inc;
          end
        end else if (!out_valid_o) begin
          // Locked channel went idle or ran dry: release so IDLE arbitrates next cycle.
          state_d = IDLE;
          rr_d    = wrap_inc(lock_q);
          beat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < int'(NumChan); i++) begin
      credit_d[i] = credit_q[i];
      if (chan_ready_o[i] && !credit_ret_i[i]) begin
        credit_d[i] = credit_q[i] - cnt_t'(1);
      end else if (credit_ret_i[i] && !chan_ready_o[i]) begin
        if (credit_q[i] == cnt_t'(InitCredits)) err_set = 1'b1;
        else credit_d[i] = credit_q[i] + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(NumChan); i++) credit_q[i] <= cnt_t'(InitCredits);
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      err_q   <= err_q | err_set;
      for (int i = 0; i < int'(NumChan); i++) credit_q[i] <= credit_d[i];
    end
  end

  assign credit_err_o = err_q;

`ifndef ignore_assert
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(chan_ready_o));
  a_offer_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(sel_idx_o) && chan_valid_i[sel_idx_o]));
  for (genvar g = 0; g < int'(NumChan); g++) begin : g_uf
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      chan_ready_o[g] |-> (credit_q[g] != '0));
  end
`endif

endmodule

// File: tb/tb_floo_axis_link_scheduler.sv
// Purpose : directed bench for floo_axis_link_scheduler with a beat scoreboard.
// Latency : expected channel indices are queued at stimulus time and popped per handshake.
// Backpr. : out_ready_i is driven low for the hold scenario only.
module tb_floo_axis_link_scheduler;

  localparam int NC = 3;
  localparam int IC = 4;
  localparam int MB = 2;
  localparam int CW = 3;
  localparam int IW = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [NC-1:0]    chan_valid_i = '0;
  logic [NC-1:0]    chan_ready_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [IW-1:0]    sel_idx_o;
  logic [NC-1:0]    credit_ret_i = '0;
  logic [NC*CW-1:0] credit_cnt_o;
  logic             credit_err_o;

  floo_axis_link_scheduler #(.NumChan(NC), .InitCredits(IC), .MaxBurst(MB)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .chan_valid_i (chan_valid_i),
    .chan_ready_o (chan_ready_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .sel_idx_o    (sel_idx_o),
    .credit_ret_i (credit_ret_i),
    .credit_cnt_o (credit_cnt_o),
    .credit_err_o (credit_err_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int exp_q[$];
  int mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [31:0] cred(input int i);
    return 32'(credit_cnt_o[i*CW +: CW]);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input int target, input string name);
    int n;
    n = 0;
    while (exp_q.size() > target && n < 60) begin
      step();
      n++;
    end
    chk(name, exp_q.size(), target);
  endtask

  task automatic chk_creds(input string name, input int c0, input int c1, input int c2);
    chk({name, "_c0"}, cred(0), c0);
    chk({name, "_c1"}, cred(1), c1);
    chk({name, "_c2"}, cred(2), c2);
  endtask

  // Scoreboard monitor: samples on the falling edge, one pop per handshake.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_beat: got beat on ch %0d, expected no beat", sel_idx_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_sel", sel_idx_o, mon_e);
          chk("beat_chan_ready", chan_ready_o, 1 << mon_e);
        end
      end else begin
        chk("no_hs_chan_ready", chan_ready_o, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_chan_ready", chan_ready_o, 0);
    chk("rst_sel", sel_idx_o, 0);
    chk_creds("rst_cred", IC, IC, IC);
    chk("rst_err", credit_err_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    step();
    chk("idle_out_valid", out_valid_o, 0);

    // Round-robin with bursts of two, then credit exhaustion
    out_ready_i = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++) begin
        exp_q.push_back(c);
        exp_q.push_back(c);
      end
    chan_valid_i = '1;
    drain(6, "rr_round1");
    chk_creds("rr_round1_cred", 2, 2, 2);
    drain(0, "rr_round2");
    chk_creds("rr_round2_cred", 0, 0, 0);
    chk("rr_dry_out_valid", out_valid_o, 0);
    chan_valid_i = '0;
    credit_ret_i = '1;
    repeat (4) step();
    credit_ret_i = '0;
    chk_creds("refill_cred", IC, IC, IC);
    chk("refill_err", credit_err_o, 0);

    // Backpressure hold: ch1 offered, ch0 arrives later and must not preempt
    out_ready_i  = 1'b0;
    chan_valid_i = 3'b010;
    #1;
    chk("hold_valid_c1", out_valid_o, 1);
    chk("hold_sel_c1", sel_idx_o, 1);
    step();
    chan_valid_i = 3'b011;
    #1;
    chk("hold_valid_c2", out_valid_o, 1);
    chk("hold_sel_c2", sel_idx_o, 1);
    step();
    #1;
    chk("hold_valid_c3", out_valid_o, 1);
    chk("hold_sel_c3", sel_idx_o, 1);
    step();
    exp_q.push_back(1);
    out_ready_i = 1'b1;
    step();
    chan_valid_i = '0;
    chk("hold_cred1", cred(1), 3);
    chk("hold_q_empty", exp_q.size(), 0);
    step();

    // Credit starvation on ch2, then a single returned credit
    repeat (4) exp_q.push_back(2);
    chan_valid_i = 3'b100;
    drain(0, "starve_beats");
    chk("starve_out_valid", out_valid_o, 0);
    chk("starve_cred2", cred(2), 0);
    step();
    step();
    chk("starve_still_idle", out_valid_o, 0);
    exp_q.push_back(2);
    credit_ret_i = 3'b100;
    step();
    credit_ret_i = '0;
    repeat (3) step();
    chk("starve_one_more", exp_q.size(), 0);
    chk("starve_after_valid", out_valid_o, 0);
    chk("starve_after_cred2", cred(2), 0);
    chan_valid_i = '0;
    credit_ret_i = 3'b110;
    step();
    credit_ret_i = 3'b100;
    repeat (3) step();
    credit_ret_i = '0;
    chk_creds("restore_cred", IC, IC, IC);
    chk("restore_err", credit_err_o, 0);

    // Consume and return in the same cycle, then overflow return
    exp_q.push_back(0);
    exp_q.push_back(0);
    chan_valid_i = 3'b001;
    step();
    credit_ret_i = 3'b001;
    step();
    credit_ret_i = '0;
    chan_valid_i = '0;
    chk("cons_ret_cred0", cred(0), 3);
    chk("cons_ret_err", credit_err_o, 0);
    credit_ret_i = 3'b001;
    step();
    credit_ret_i = '0;
    chk("ret_to_full_cred0", cred(0), 4);
    chk("ret_to_full_err", credit_err_o, 0);
    credit_ret_i = 3'b001;
    step();
    credit_ret_i = '0;
    chk("overflow_cred0", cred(0), 4);
    chk("overflow_err", credit_err_o, 1);
    repeat (3) step();
    chk("overflow_err_sticky", credit_err_o, 1);

    // Burst early release: ch0 one beat, then ch1 right after the release cycle
    exp_q.push_back(0);
    exp_q.push_back(1);
    chan_valid_i = 3'b001;
    step();
    chan_valid_i = 3'b010;
    #1;
    chk("release_cycle_valid", out_valid_o, 0);
    step();
    #1;
    chk("release_next_valid", out_valid_o, 1);
    chk("release_next_sel", sel_idx_o, 1);
    step();
    chan_valid_i = '0;
    chk("release_q_empty", exp_q.size(), 0);
    step();
    step();

    // Reset in the middle of a burst with credit0 down to one
    exp_q.push_back(0);
    chan_valid_i = 3'b001;
    step();
    chan_valid_i = '0;
    step();
    exp_q.push_back(0);
    chan_valid_i = 3'b001;
    step();
    #1;
    chk("pre_rst_cred0", cred(0), 1);
    chk("pre_rst_valid", out_valid_o, 1);
    #1;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_chan_ready", chan_ready_o, 0);
    chk("mid_rst_sel", sel_idx_o, 0);
    chk_creds("mid_rst_cred", IC, IC, IC);
    chk("mid_rst_err", credit_err_o, 0);
    chk("mid_rst_q_empty", exp_q.size(), 0);
    chan_valid_i = '0;
    step();
    step();
    rst_i = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(1);
    chan_valid_i = '1;
    drain(0, "post_rst_rr");
    chan_valid_i = '0;
    step();
    step();

    chk("end_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
